pong_ball_controller: RTL and testbench
=======================================

# pong_ball_controller

Game sequencer for the LED ping-pong table. Drives the 6-bit ball-position code consumed by the LED decoder, where 0 is the idle pattern, 1..16 light a single LED (1 = led[0], right end; 16 = led[15], left end) and 17 is the point/game-over pattern. It handles serve, ball travel, paddle-hit windows, scoring and game end. Sits between the debounced button/tick generators and the LED decoder.

## Interface
- WIN_SCORE, 7: points needed to win; legal range 1..15.
- POINT_TICKS, 4: ticks the point pattern (17) is held after a miss; minimum 1.
- clk_game  in  1  game clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- tick  in  1  one-cycle game-speed enable pulse; the ball advances only on tick.
- start  in  1  one-cycle pulse; starts a new game from IDLE or GAME_OVER.
- btn_left  in  1  one-cycle debounced pulse, left paddle (position 16).
- btn_right  in  1  one-cycle debounced pulse, right paddle (position 1).
- counter  out  6  ball-position code for the LED decoder.
- score_left  out  4  left player score.
- score_right  out  4  right player score.
- game_over  out  1  high while in GAME_OVER.

## Operation
- States: IDLE, SERVE, MOVE_LEFT (position increasing), MOVE_RIGHT (position decreasing), POINT, GAME_OVER.
- Reset: IDLE, counter=0, scores=0, game_over=0, server=right, hit flag=0, point timer=0.
- IDLE: counter=0. start -> SERVE, scores cleared, server=right.
- SERVE: counter is the server's end (1 for right, 16 for left). A press of the server's own button -> MOVE_LEFT (right server) or MOVE_RIGHT (left server). All other buttons and ticks are ignored.
- MOVE_*: each tick moves the ball one step toward the far end. On arrival at the end (16 for MOVE_LEFT, 1 for MOVE_RIGHT) the hit window opens and the hit flag clears.
- Hit window: the receiving player's button while the ball sits at their end sets the hit flag. Extra presses have no effect. Presses by the other player, or at any other position, are ignored.
- Next tick with the ball at an end:
  - Hit flag set: reverse direction and step one position (16->15 or 1->2) in the same tick.
  - Hit flag clear: miss. The opponent's score increments, server becomes the player who missed, and the state goes to POINT.
- POINT: counter=17 for POINT_TICKS ticks. Then go to GAME_OVER if either score equals WIN_SCORE, else to SERVE.
- GAME_OVER: counter=17, game_over=1, scores held. start -> SERVE, scores cleared, server=right.
- start outside IDLE/GAME_OVER is ignored.
- Scores never exceed WIN_SCORE, because the game ends on reaching it.

## Timing
- All outputs are registered and change one clk_game cycle after the qualifying input edge. There is no combinational input->output path.
- Button and tick in the same cycle with the ball at an end: the press counts, and that tick returns the ball.
- A serve press launches in the next cycle. The ball stays at the end position until the following tick, then steps.
- Score increment and the change to counter=17 occur in the same cycle as the miss tick.
- The POINT hold spans exactly POINT_TICKS tick pulses after the miss tick.
- Asynchronous reset mid-rally or mid-POINT forces IDLE immediately. No partial score survives.
- Each tick moves the ball at most one position.

## Structure
- Shared package pong_pkg holds:
  - the state enum;
  - constants POS_RIGHT_END=1, POS_LEFT_END=16, PAT_IDLE=0, PAT_POINT=17;
  - the side encoding (LEFT/RIGHT).
- The LED decoder reuses these pattern constants.
- One natural sub-module, pong_score_keeper: two 4-bit counters with clear, increment-by-side, and a win compare against WIN_SCORE.

## Test plan
- Reset, then start: counter=0 -> 1. Right press, then 15 ticks: counter steps 1..16, one per tick.
- Ball at 16, btn_left, then tick: counter=15, state MOVE_RIGHT. Repeat at 1 with btn_right: counter=2.
- Ball at 16, no press, tick: score_right=1, counter=17 for POINT_TICKS=4 ticks, then counter=16 (left serves).
- Ball at 16, btn_left and tick in the same cycle: return to 15. btn_right at 16 and btn_left at position 10: both ignored, so miss.
- Left reaches WIN_SCORE=7: game_over=1, counter=17, scores 7/x held. start: scores 0/0, counter=1.
- Assert rst at ball position 9 mid-rally: next observed counter=0, scores 0, game_over=0. Subsequent start works normally.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and position/pattern codes for the LED ping-pong table.
// Also used by the LED decoder, which maps these codes to lamps.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE,
        ST_MOVE_LEFT,
        ST_MOVE_RIGHT,
        ST_POINT,
        ST_GAME_OVER
    } state_t;

    typedef enum logic {
        SIDE_RIGHT = 1'b0,
        SIDE_LEFT  = 1'b1
    } side_t;

    localparam logic [5:0] POS_RIGHT_END = 6'd1;
    localparam logic [5:0] POS_LEFT_END  = 6'd16;
    localparam logic [5:0] PAT_IDLE      = 6'd0;
    localparam logic [5:0] PAT_POINT     = 6'd17;

    function automatic logic [5:0] serve_pos(input side_t s);
        return (s == SIDE_LEFT) ? POS_LEFT_END : POS_RIGHT_END;
    endfunction

endpackage

// File: rtl/pong_ball_controller_if.sv
// Player/tick inputs and display outputs of the ball controller.
// The master modport is the input side, the slave modport is the controller.
interface pong_ball_controller_if;
    logic       tick;
    logic       start;
    logic       btn_left;
    logic       btn_right;
    logic [5:0] counter;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;

    modport master (
        output tick, start, btn_left, btn_right,
        input  counter, score_left, score_right, game_over
    );

    modport slave (
        input  tick, start, btn_left, btn_right,
        output counter, score_left, score_right, game_over
    );
endinterface

// File: rtl/pong_score_keeper.sv
// Two 4-bit player scores with clear, increment-by-side and a win compare.
import pong_pkg::*;

module pong_score_keeper #(
    parameter int WIN_SCORE = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_inc,
    input  side_t      i_side,
    output logic [3:0] o_score_left,
    output logic [3:0] o_score_right,
    output logic       o_win
);
    logic [3:0] r_left;
    logic [3:0] r_right;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_left  <= 4'd0;
            r_right <= 4'd0;
        end else if (i_clear) begin
            r_left  <= 4'd0;
            r_right <= 4'd0;
        end else if (i_inc) begin
            if (i_side == SIDE_LEFT)
                r_left <= r_left + 4'd1;
            else
                r_right <= r_right + 4'd1;
        end
    end

    assign o_score_left  = r_left;
    assign o_score_right = r_right;
    assign o_win = (r_left == 4'(WIN_SCORE)) ||
                   (r_right == 4'(WIN_SCORE));
endmodule

// File: rtl/pong_ball_controller.sv
// Game sequencer: serve, ball travel, paddle-hit windows, scoring, game end.
import pong_pkg::*;

module pong_ball_controller #(
    parameter int WIN_SCORE   = 7,
    parameter int POINT_TICKS = 4
) (
    input logic clk_game,
    input logic rst,
    pong_ball_controller_if.slave bus
);
    localparam int PTW = (POINT_TICKS < 2) ? 1 : $clog2(POINT_TICKS);

    state_t         r_state;
    logic [5:0]     r_counter;
    side_t          r_server;
    logic           r_hit;
    logic [PTW-1:0] r_pt_cnt;
    logic           r_game_over;

    logic  w_at_end;
    logic  w_rcv_btn;
    logic  w_hit;
    logic  w_miss;
    logic  w_clear;
    logic  w_win;
    side_t w_scorer;

    always_comb begin
        w_at_end  = 1'b0;
        w_rcv_btn = 1'b0;
        w_scorer  = SIDE_RIGHT;
        if (r_state == ST_MOVE_LEFT) begin
            w_at_end  = (r_counter == POS_LEFT_END);
            w_rcv_btn = bus.btn_left;
            w_scorer  = SIDE_RIGHT;
        end else if (r_state == ST_MOVE_RIGHT) begin
            w_at_end  = (r_counter == POS_RIGHT_END);
            w_rcv_btn = bus.btn_right;
            w_scorer  = SIDE_LEFT;
        end
        // a press landing on the return tick still counts
        w_hit   = r_hit | w_rcv_btn;
        w_miss  = w_at_end & bus.tick & ~w_hit;
        w_clear = bus.start &
                  ((r_state == ST_IDLE) || (r_state == ST_GAME_OVER));
    end

    pong_score_keeper #(
        .WIN_SCORE(WIN_SCORE)
    ) u_score (
        .clk          (clk_game),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_inc        (w_miss),
        .i_side       (w_scorer),
        .o_score_left (bus.score_left),
        .o_score_right(bus.score_right),
        .o_win        (w_win)
    );

    always_ff @(posedge clk_game or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_counter   <= PAT_IDLE;
            r_server    <= SIDE_RIGHT;
            r_hit       <= 1'b0;
            r_pt_cnt    <= '0;
            r_game_over <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_GAME_OVER: begin
                    if (bus.start) begin
                        r_state     <= ST_SERVE;
                        r_server    <= SIDE_RIGHT;
                        r_counter   <= POS_RIGHT_END;
                        r_hit       <= 1'b0;
                        r_game_over <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    r_counter <= serve_pos(r_server);
                    r_hit     <= 1'b0;
                    if (r_server == SIDE_RIGHT && bus.btn_right)
                        r_state <= ST_MOVE_LEFT;
                    else if (r_server == SIDE_LEFT && bus.btn_left)
                        r_state <= ST_MOVE_RIGHT;
                end
                ST_MOVE_LEFT: begin
                    if (bus.tick) begin
                        if (!w_at_end) begin
                            r_counter <= r_counter + 6'd1;
                            r_hit     <= 1'b0;
                        end else if (w_hit) begin
                            r_state   <= ST_MOVE_RIGHT;
                            r_counter <= POS_LEFT_END - 6'd1;
                            r_hit     <= 1'b0;
                        end else begin
                            r_state   <= ST_POINT;
                            r_counter <= PAT_POINT;
                            r_server  <= SIDE_LEFT;
                            r_pt_cnt  <= '0;
                        end
                    end else if (w_at_end && w_rcv_btn) begin
                        r_hit <= 1'b1;
                    end
                end
                ST_MOVE_RIGHT: begin
                    if (bus.tick) begin
                        if (!w_at_end) begin
                            r_counter <= r_counter - 6'd1;
                            r_hit     <= 1'b0;
                        end else if (w_hit) begin
                            r_state   <= ST_MOVE_LEFT;
                            r_counter <= POS_RIGHT_END + 6'd1;
                            r_hit     <= 1'b0;
                        end else begin
                            r_state   <= ST_POINT;
                            r_counter <= PAT_POINT;
                            r_server  <= SIDE_RIGHT;
                            r_pt_cnt  <= '0;
                        end
                    end else if (w_at_end && w_rcv_btn) begin
                        r_hit <= 1'b1;
                    end
                end
                ST_POINT: begin
                    if (bus.tick) begin
                        if (r_pt_cnt == PTW'(POINT_TICKS - 1)) begin
                            r_pt_cnt <= '0;
                            if (w_win) begin
                                r_state     <= ST_GAME_OVER;
                                r_counter   <= PAT_POINT;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state   <= ST_SERVE;
                                r_counter <= serve_pos(r_server);
                            end
                        end else begin
                            r_pt_cnt <= r_pt_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_counter <= PAT_IDLE;
                end
            endcase
        end
    end

    assign bus.counter   = r_counter;
    assign bus.game_over = r_game_over;
endmodule

// File: tb/tb_pong_ball_controller.sv
// Directed bench for pong_ball_controller with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_pong_ball_controller;
    logic clk_game = 1'b0;
    logic rst      = 1'b1;
    int   n_total  = 0;
    int   n_bad    = 0;

    pong_ball_controller_if bus ();

    pong_ball_controller #(
        .WIN_SCORE  (7),
        .POINT_TICKS(4)
    ) dut (
        .clk_game(clk_game),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_game = ~clk_game;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic t, input logic s,
                        input logic bl, input logic br);
        bus.tick      = t;
        bus.start     = s;
        bus.btn_left  = bl;
        bus.btn_right = br;
        @(posedge clk_game);
        #1;
        bus.tick      = 1'b0;
        bus.start     = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got 0 want 1");
        $fatal(1, "timeout");
    end

    initial begin
        bus.tick      = 1'b0;
        bus.start     = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        repeat (2) @(posedge clk_game);
        #1;
        chk("rst_cnt", bus.counter, 0);
        chk("rst_sl", bus.score_left, 0);
        chk("rst_sr", bus.score_right, 0);
        chk("rst_go", bus.game_over, 0);
        rst = 1'b0;
        step(0, 0, 0, 0);
        chk("idle_cnt", bus.counter, 0);

        step(0, 1, 0, 0);
        chk("start", bus.counter, 1);
        step(0, 0, 0, 1);
        chk("launch_hold", bus.counter, 1);
        for (int i = 0; i < 15; i++) begin
            step(1, 0, 0, 0);
            chk("travel_l", bus.counter, i + 2);
        end
        step(0, 0, 1, 0);
        chk("hit_l_hold", bus.counter, 16);
        step(1, 0, 0, 0);
        chk("ret_l", bus.counter, 15);
        ticks(14);
        chk("reach_r", bus.counter, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("ret_r", bus.counter, 2);
        step(0, 1, 0, 0);
        chk("start_ign", bus.counter, 2);
        chk("start_ign_sr", bus.score_right, 0);
        ticks(14);
        chk("reach_l2", bus.counter, 16);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("miss_l_cnt", bus.counter, 17);
        chk("miss_l_sr", bus.score_right, 1);
        chk("miss_l_sl", bus.score_left, 0);
        ticks(3);
        chk("point_hold", bus.counter, 17);
        step(1, 0, 0, 0);
        chk("serve_left", bus.counter, 16);

        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("serve_wrong", bus.counter, 16);
        step(0, 0, 1, 0);
        ticks(15);
        chk("travel_r", bus.counter, 1);
        step(1, 0, 0, 1);
        chk("same_cyc_r", bus.counter, 2);
        ticks(14);
        step(1, 0, 1, 0);
        chk("same_cyc_l", bus.counter, 15);
        ticks(5);
        chk("at_10", bus.counter, 10);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        ticks(9);
        chk("reach_r2", bus.counter, 1);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        chk("miss_r_cnt", bus.counter, 17);
        chk("miss_r_sl", bus.score_left, 1);
        chk("miss_r_sr", bus.score_right, 1);

        for (int k = 2; k <= 7; k++) begin
            ticks(4);
            chk("serve_right", bus.counter, 1);
            step(0, 0, 0, 1);
            ticks(15);
            step(1, 0, 1, 0);
            ticks(14);
            step(1, 0, 0, 0);
            chk("rally_cnt", bus.counter, 17);
            chk("rally_sl", bus.score_left, k);
        end
        ticks(4);
        chk("go_cnt", bus.counter, 17);
        chk("go_flag", bus.game_over, 1);
        chk("go_sl", bus.score_left, 7);
        chk("go_sr", bus.score_right, 1);
        ticks(2);
        step(0, 0, 1, 1);
        chk("go_hold_cnt", bus.counter, 17);
        chk("go_hold_sl", bus.score_left, 7);
        step(0, 1, 0, 0);
        chk("restart_cnt", bus.counter, 1);
        chk("restart_sl", bus.score_left, 0);
        chk("restart_sr", bus.score_right, 0);
        chk("restart_go", bus.game_over, 0);

        step(0, 0, 0, 1);
        ticks(8);
        chk("mid_9", bus.counter, 9);
        #1 rst = 1'b1;
        #1;
        chk("arst_cnt", bus.counter, 0);
        chk("arst_sl", bus.score_left, 0);
        chk("arst_go", bus.game_over, 0);
        @(posedge clk_game);
        #1 rst = 1'b0;
        step(0, 1, 0, 0);
        chk("post_rst_start", bus.counter, 1);
        step(0, 0, 0, 1);
        ticks(15);
        step(1, 0, 0, 0);
        chk("pt2_sr", bus.score_right, 1);
        ticks(2);
        #1 rst = 1'b1;
        #1;
        chk("arst_pt_cnt", bus.counter, 0);
        chk("arst_pt_sr", bus.score_right, 0);
        @(posedge clk_game);
        #1 rst = 1'b0;
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("post_rst2", bus.counter, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
